block_instr_sequencer: RTL
==========================

// Module: block_instr_sequencer
// PURPOSE
// Per-sample instruction sequencer for one processing block. On each sample_tick it fetches
// the block program (32-bit words) from instruction memory, decodes each word with an
// instr_decoder, holds issue on register/accumulator hazards, and hands instructions to the
// execute pipeline over a valid/ready handshake. Sits between the program memory and the
// branch datapaths (MADD/MAC/MISC/DELAY/LUT/MEM).
// PARAMETERS
// PROG_DEPTH   64  instruction memory depth, in words
// N_REGS       16  channel registers tracked by the scoreboard (matches the 4-bit src/dest fields)
// ACC_CNT_W    4   width of the in-flight MAC counter
// PORTS
// clk             in   1                   system clock
// reset           in   1                   synchronous, active-high
// sample_tick     in   1                   start-of-sample pulse
// n_instrs        in   $clog2(PROG_DEPTH)+1  program length; sampled on an accepted tick
// instr_addr      out  $clog2(PROG_DEPTH)  program memory read address
// instr_rdata     in   32                  program word; valid 1 cycle after instr_addr
// issue_valid     out  1                   issue_instr is valid
// issue_ready     in   1                   pipeline accepts the instruction
// issue_instr     out  32                  instruction word being issued
// wb_valid        in   1                   a channel register write has retired
// wb_reg          in   4                   register retired by wb_valid
// acc_retire      in   1                   a MAC-branch instruction has retired
// busy            out  1                   the sequencer is not in IDLE
// sample_done     out  1                   1-cycle pulse when the program has fully drained
// overrun         out  1                   sticky; sample_tick arrived while busy
// stall_cycles    out  16                  saturating count of hazard-stalled ISSUE cycles
// BEHAVIOUR
// - Reset: state=IDLE, pc=0, scoreboard=0, acc_cnt=0; all outputs are 0.
//   Reset in mid-program abandons the program; no sample_done pulse is generated.
// - IDLE: on sample_tick, latch n_instrs and set pc=0. If n_instrs==0, go to DRAIN; else go to FETCH.
// - FETCH: drive instr_addr=pc. Go to ISSUE on the next cycle, when the word is registered.
// - ISSUE: the decoder runs on the registered word. A hazard exists if any of these holds:
//   (a) arg_x_needed && src_x_reg && sb[src_x], for x in a,b,c (RAW);
//   (b) writes_channel && sb[dest] (WAW);
//   (c) accumulator_needed && acc_cnt!=0;
//   (d) writes_acc && acc_cnt==max (counter full).
//   issue_valid = !hazard. On a hazard, hold and count a stall.
//   Handshake: issue_valid && issue_ready is a transfer. Once asserted, issue_valid and
//   issue_instr stay stable until the transfer completes.
//   On transfer: set sb[dest] if writes_channel; acc_cnt++ if writes_acc; pc++.
//   If pc+1==n_instrs go to DRAIN, else go to FETCH. Throughput is 1 instruction per 2 cycles.
// - Writes to external/MAC branches never set the scoreboard. commit_flag is not interpreted here.
// - Retire: wb_valid clears sb[wb_reg]; acc_retire decrements acc_cnt.
//   Retire and issue on the same register in the same cycle: the set wins.
//   acc issue and acc_retire in the same cycle: acc_cnt is unchanged.
//   acc_retire at acc_cnt==0 is ignored.
// - DRAIN: when sb==0 && acc_cnt==0, pulse sample_done and return to IDLE.
// - sample_tick while busy: the tick is ignored and overrun is set (cleared only by reset).
//   A tick in the same cycle as sample_done is also ignored and flagged.
// - stall_cycles saturates at 16'hFFFF and is cleared only by reset.
// STRUCTURE
// - Shared package seq_pkg: typedef enum {IDLE, FETCH, ISSUE, DRAIN} seq_state_t.
//   Hazard helper function(s) also live in seq_pkg.
// - Opcode and branch constants come from the shared instruction header (`BLOCK_INSTR_*, `INSTR_BRANCH_*).
// - One sub-module: instr_decoder, instantiated on the registered instruction word.
//   Scoreboard and counters are kept inline.
// TESTING
// 1 n_instrs=3, 3 independent MADDs, issue_ready=1, immediate wb -> 3 issues at cycles 2,4,6
//   after the tick; sample_done at cycle 7 or later; stall_cycles=0.
// 2 MADD dest=r5, then MADD src_a=r5 (reg); wb for r5 delayed 4 cycles -> 2nd issue held
//   4 cycles, stall_cycles=4, issued the cycle after wb.
// 3 MAC, MAC, MOV_ACC; acc_retire after 3 cycles each -> MOV_ACC issues only once acc_cnt==0;
//   no sample_done while acc_cnt!=0.
// 4 issue_ready=0 for 5 cycles during ISSUE -> issue_valid and issue_instr are stable all
//   5 cycles; pc advances once.
// 5 sample_tick mid-program, and n_instrs=0 -> overrun=1 and the program is unaffected;
//   n_instrs=0 gives sample_done 2 cycles after the tick.
// 6 reset asserted in ISSUE with sb!=0 -> next cycle: IDLE, all outputs 0, no sample_done.

Source files
------------

// File: rtl/block_instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the block instruction sequencer.
//
// Instruction word layout (32 bits):
//   [31:26] opcode
//   [25]    commit_flag   (carried through to the pipeline, not used here)
//   [24]    src_a_reg     1 = src_a names a channel register
//   [23]    src_b_reg
//   [22]    src_c_reg
//   [21:20] reserved
//   [19:16] dest
//   [15:12] src_a
//   [11:8]  src_b
//   [7:4]   src_c
//   [3:0]   immediate / modifier bits (used by the branch datapaths only)
//
// Contents:
//   seq_state_t        sequencer FSM states
//   INSTR_BRANCH_*     execute branch identifiers
//   BLOCK_INSTR_*      opcodes
//   decoded_t          decoder output bundle
//   issue_hazard()     combined RAW / WAW / accumulator hazard check
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int INSTR_W   = 32;
  localparam int OPCODE_W  = 6;
  localparam int REG_IDX_W = 4;
  localparam int BRANCH_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DRAIN
  } seq_state_t;

  // Execute branches
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MADD  = 3'd0;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MAC   = 3'd1;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MISC  = 3'd2;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_DELAY = 3'd3;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_LUT   = 3'd4;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_MEM   = 3'd5;
  localparam logic [BRANCH_W-1:0] INSTR_BRANCH_EXT   = 3'd6;

  // Opcodes
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_NOP     = 6'h00;
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_MADD    = 6'h01;  // dest = a*b + c
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_MAC     = 6'h02;  // acc += a*b
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_MOV     = 6'h03;  // dest = a
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_MOV_ACC = 6'h04;  // dest = acc
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_DELAY   = 6'h05;  // dest = delayline(a)
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_LUT     = 6'h06;  // dest = lut(a)
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_LOAD    = 6'h07;  // dest = mem
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_STORE   = 6'h08;  // mem = a
  localparam logic [OPCODE_W-1:0] BLOCK_INSTR_EXT_OUT = 6'h09;  // external port = a

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [REG_IDX_W-1:0] src_a;
    logic [REG_IDX_W-1:0] src_b;
    logic [REG_IDX_W-1:0] src_c;
    logic                 src_a_reg;
    logic                 src_b_reg;
    logic                 src_c_reg;
    logic                 arg_a_needed;
    logic                 arg_b_needed;
    logic                 arg_c_needed;
    logic                 writes_channel;
    logic                 writes_acc;
    logic                 accumulator_needed;
  } decoded_t;

  // busy_* are the scoreboard bits addressed by the instruction's register
  // fields; acc_empty/acc_full describe the in-flight MAC counter.
  function automatic logic issue_hazard(
    input decoded_t d,
    input logic     busy_a,
    input logic     busy_b,
    input logic     busy_c,
    input logic     busy_dest,
    input logic     acc_empty,
    input logic     acc_full
  );
    logic raw;
    logic waw;
    logic acc_wait;
    raw = (d.arg_a_needed && d.src_a_reg && busy_a) ||
          (d.arg_b_needed && d.src_b_reg && busy_b) ||
          (d.arg_c_needed && d.src_c_reg && busy_c);
    waw = d.writes_channel && busy_dest;
    acc_wait = (d.accumulator_needed && !acc_empty) ||
               (d.writes_acc && acc_full);
    return raw || waw || acc_wait;
  endfunction

endpackage

// File: rtl/block_instr_sequencer_instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of one program word into the operand/result
// usage the sequencer needs for hazard tracking.
//
// Ports:
//   instr  in   32   program word
//   dec    out  decoded_t  register fields plus usage flags
//
// Results going to the MAC accumulator or to the external port are not
// channel-register writes, so they never mark the scoreboard.
// ---------------------------------------------------------------------------
module instr_decoder
  import seq_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output decoded_t           dec
);

  logic [OPCODE_W-1:0] opcode;
  logic [BRANCH_W-1:0] branch;
  logic                has_dest;
  logic                unused_fields;

  assign opcode = instr[31:26];

  // commit_flag, reserved and immediate bits belong to the datapaths.
  assign unused_fields = ^{instr[25], instr[21:20], instr[3:0]};

  always_comb begin
    dec                = '0;
    branch             = INSTR_BRANCH_MISC;
    has_dest           = 1'b0;
    dec.dest           = instr[19:16];
    dec.src_a          = instr[15:12];
    dec.src_b          = instr[11:8];
    dec.src_c          = instr[7:4];
    dec.src_a_reg      = instr[24];
    dec.src_b_reg      = instr[23];
    dec.src_c_reg      = instr[22];

    case (opcode)
      BLOCK_INSTR_MADD: begin
        branch           = INSTR_BRANCH_MADD;
        dec.arg_a_needed = 1'b1;
        dec.arg_b_needed = 1'b1;
        dec.arg_c_needed = 1'b1;
        has_dest         = 1'b1;
      end
      BLOCK_INSTR_MAC: begin
        branch           = INSTR_BRANCH_MAC;
        dec.arg_a_needed = 1'b1;
        dec.arg_b_needed = 1'b1;
        dec.writes_acc   = 1'b1;
      end
      BLOCK_INSTR_MOV: begin
        branch           = INSTR_BRANCH_MISC;
        dec.arg_a_needed = 1'b1;
        has_dest         = 1'b1;
      end
      BLOCK_INSTR_MOV_ACC: begin
        branch                 = INSTR_BRANCH_MISC;
        dec.accumulator_needed = 1'b1;
        has_dest               = 1'b1;
      end
      BLOCK_INSTR_DELAY: begin
        branch           = INSTR_BRANCH_DELAY;
        dec.arg_a_needed = 1'b1;
        has_dest         = 1'b1;
      end
      BLOCK_INSTR_LUT: begin
        branch           = INSTR_BRANCH_LUT;
        dec.arg_a_needed = 1'b1;
        has_dest         = 1'b1;
      end
      BLOCK_INSTR_LOAD: begin
        branch   = INSTR_BRANCH_MEM;
        has_dest = 1'b1;
      end
      BLOCK_INSTR_STORE: begin
        branch           = INSTR_BRANCH_MEM;
        dec.arg_a_needed = 1'b1;
      end
      BLOCK_INSTR_EXT_OUT: begin
        branch           = INSTR_BRANCH_EXT;
        dec.arg_a_needed = 1'b1;
        has_dest         = 1'b1;
      end
      default: begin
        // NOP and unallocated opcodes: no operands, no result.
        branch = INSTR_BRANCH_MISC;
      end
    endcase

    dec.writes_channel = has_dest &&
                         (branch != INSTR_BRANCH_EXT) &&
                         (branch != INSTR_BRANCH_MAC);
  end

endmodule

// File: rtl/block_instr_sequencer.sv
// ---------------------------------------------------------------------------
// block_instr_sequencer
// Per-sample instruction sequencer. Each accepted sample_tick walks the block
// program: FETCH drives the read address, ISSUE decodes the returned word,
// holds on hazards and offers it on a valid/ready handshake, DRAIN waits for
// every in-flight register write and MAC to retire before pulsing
// sample_done.
//
// Ports:
//   clk           in   1        system clock
//   reset         in   1        synchronous, active-high
//   sample_tick   in   1        start-of-sample pulse
//   n_instrs      in   AW+1     program length, captured on an accepted tick
//   instr_addr    out  AW       program memory read address
//   instr_rdata   in   32       program word, valid one cycle after instr_addr
//   issue_valid   out  1        issue_instr is valid
//   issue_ready   in   1        pipeline accepts the instruction
//   issue_instr   out  32       instruction being offered
//   wb_valid      in   1        a channel register write has retired
//   wb_reg        in   4        register retired by wb_valid
//   acc_retire    in   1        a MAC-branch instruction has retired
//   busy          out  1        sequencer not idle
//   sample_done   out  1        one-cycle pulse once the program has drained
//   overrun       out  1        sticky: tick arrived while busy / on sample_done
//   stall_cycles  out  16       saturating count of hazard-held ISSUE cycles
// ---------------------------------------------------------------------------
module block_instr_sequencer
  import seq_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int N_REGS     = 16,
  parameter int ACC_CNT_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [$clog2(PROG_DEPTH):0]   n_instrs,
  output logic [$clog2(PROG_DEPTH)-1:0] instr_addr,
  input  logic [INSTR_W-1:0]            instr_rdata,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [INSTR_W-1:0]            issue_instr,
  input  logic                          wb_valid,
  input  logic [REG_IDX_W-1:0]          wb_reg,
  input  logic                          acc_retire,
  output logic                          busy,
  output logic                          sample_done,
  output logic                          overrun,
  output logic [15:0]                   stall_cycles
);

  localparam int ADDR_W = $clog2(PROG_DEPTH);
  localparam int LEN_W  = ADDR_W + 1;

  seq_state_t             state_reg, state_next;
  logic [ADDR_W-1:0]      pc_reg, pc_next;
  logic [LEN_W-1:0]       len_reg, len_next;
  logic [LEN_W-1:0]       pc_plus1;
  logic [N_REGS-1:0]      sb_reg, sb_next, sb_set, sb_clr;
  logic [ACC_CNT_W-1:0]   acc_cnt_reg, acc_cnt_next;
  logic [15:0]            stall_reg, stall_next;
  logic                   overrun_reg, overrun_next;
  logic                   done_reg, done_next;

  decoded_t               dec;
  logic                   in_issue;
  logic                   hazard;
  logic                   xfer;
  logic                   acc_inc;
  logic                   acc_dec;
  logic                   tick_rejected;

  // The read address is held at pc throughout ISSUE, so the memory keeps
  // presenting the same word; that is what keeps issue_instr stable while
  // the handshake is back-pressured.
  instr_decoder u_decoder (
    .instr (instr_rdata),
    .dec   (dec)
  );

  assign in_issue = (state_reg == ISSUE);

  assign hazard = issue_hazard(dec,
                               sb_reg[dec.src_a],
                               sb_reg[dec.src_b],
                               sb_reg[dec.src_c],
                               sb_reg[dec.dest],
                               acc_cnt_reg == '0,
                               acc_cnt_reg == '1);

  // Hazards can only clear while waiting (retires), never reappear, since
  // the scoreboard and the counter only grow on our own transfer. Hence
  // issue_valid does not drop once raised.
  assign issue_valid = in_issue && !hazard;
  assign xfer        = issue_valid && issue_ready;
  assign issue_instr = in_issue ? instr_rdata : '0;

  assign pc_plus1 = LEN_W'(pc_reg) + LEN_W'(1);

  // A tick is only taken in IDLE and not in the cycle sample_done is shown.
  assign tick_rejected = sample_tick && ((state_reg != IDLE) || done_reg);

  // ------------------------------------------------------------------
  // Scoreboard: set on issue of a channel write, cleared on write-back.
  // A set and a clear of the same bit in one cycle leaves it set.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_sb
      assign sb_set[gi]  = xfer && dec.writes_channel &&
                           (dec.dest == REG_IDX_W'(gi));
      assign sb_clr[gi]  = wb_valid && (wb_reg == REG_IDX_W'(gi));
      assign sb_next[gi] = sb_set[gi] || (sb_reg[gi] && !sb_clr[gi]);
    end
  endgenerate

  // ------------------------------------------------------------------
  // In-flight MAC counter. A retire with nothing in flight is dropped;
  // a retire paired with an issue cancels out.
  // ------------------------------------------------------------------
  assign acc_inc = xfer && dec.writes_acc;
  assign acc_dec = acc_retire && ((acc_cnt_reg != '0) || acc_inc);

  always_comb begin
    acc_cnt_next = acc_cnt_reg;
    if (acc_inc && !acc_dec) begin
      acc_cnt_next = acc_cnt_reg + ACC_CNT_W'(1);
    end else if (!acc_inc && acc_dec) begin
      acc_cnt_next = acc_cnt_reg - ACC_CNT_W'(1);
    end
  end

  assign stall_next   = (in_issue && hazard && (stall_reg != 16'hFFFF)) ?
                        stall_reg + 16'd1 : stall_reg;
  assign overrun_next = overrun_reg || tick_rejected;

  // ------------------------------------------------------------------
  // FSM next state
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sample_tick && !done_reg) begin
          len_next   = n_instrs;
          pc_next    = '0;
          state_next = (n_instrs == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        if (xfer) begin
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = (pc_plus1 == len_reg) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if ((sb_reg == '0) && (acc_cnt_reg == '0)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      len_reg     <= '0;
      sb_reg      <= '0;
      acc_cnt_reg <= '0;
      stall_reg   <= '0;
      overrun_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      len_reg     <= len_next;
      sb_reg      <= sb_next;
      acc_cnt_reg <= acc_cnt_next;
      stall_reg   <= stall_next;
      overrun_reg <= overrun_next;
      done_reg    <= done_next;
    end
  end

  assign instr_addr   = pc_reg;
  assign busy         = (state_reg != IDLE);
  assign sample_done  = done_reg;
  assign overrun      = overrun_reg;
  assign stall_cycles = stall_reg;

endmodule
